i2c_req_arbiter: RTL

- Shares one i2c_master_top register-access port (read/write req/ack, dev/reg addr, data, error) between NUM_CLIENTS independent requesters.
- Typical requesters: the power-up config sequencer, an AXI-lite register bridge and a sensor poller.
- Round-robin grant; one transaction in flight at a time.
- Returns read data and error to the granted client with a one-cycle ack pulse.

---
 rtl/i2c_arb_pkg.sv | 17 +
 rtl/i2c_rr_pick.sv | 29 ++
 rtl/i2c_req_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared encodings and defaults for the i2c_req_arbiter block.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 2_000_000;

endpackage

// File: rtl/i2c_rr_pick.sv
// Rotating-priority select: first pending requester at or above rr_ptr, wrapping modulo N.
module i2c_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         pend,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic [$clog2(N)-1:0] win_idx,
  output logic                 any
);
  localparam int IW = $clog2(N);

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Scan from the farthest offset down so the nearest pending client wins.
  always_comb begin
    win_idx = rr_ptr;
    for (int k = N - 1; k >= 0; k--) begin
      if (pend[wrap_add(rr_ptr, k)]) win_idx = wrap_add(rr_ptr, k);
    end
  end

  assign any = |pend;

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one i2c_master_top register-access port among NUM_CLIENTS requesters.
// Define I2C_ARB_TIMEOUT_EN to abort a transaction that is not acked within TIMEOUT_CYCLES.
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_CLIENTS    = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CLIENTS-1:0]           cli_rd_req,
  input  logic [NUM_CLIENTS-1:0]           cli_wr_req,
  input  logic [8*NUM_CLIENTS-1:0]         cli_dev_addr,
  input  logic [8*NUM_CLIENTS-1:0]         cli_reg_addr,
  input  logic [8*NUM_CLIENTS-1:0]         cli_wdata,
  output logic [NUM_CLIENTS-1:0]           cli_ack,
  output logic [7:0]                       cli_rdata,
  output logic                             cli_error,
  output logic                             busy,
  output logic [$clog2(NUM_CLIENTS)-1:0]   grant_id,
  output logic                             m_read_req,
  input  logic                             m_read_req_ack,
  output logic                             m_write_req,
  input  logic                             m_write_req_ack,
  output logic [7:0]                       m_dev_addr,
  output logic [7:0]                       m_reg_addr,
  output logic [7:0]                       m_wdata,
  input  logic [7:0]                       m_rdata,
  input  logic                             m_error
);
  localparam int IW = $clog2(NUM_CLIENTS);

  if (NUM_CLIENTS < 2 || NUM_CLIENTS > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("i2c_req_arbiter: NUM_CLIENTS must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  state_t                 state;
  op_t                    op;
  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          win_idx;
  logic                   any;
  logic [NUM_CLIENTS-1:0] pend;
  logic                   ack_hit;

  assign pend    = cli_rd_req | cli_wr_req;
  assign ack_hit = (op == OP_WR) ? m_write_req_ack : m_read_req_ack;

  i2c_rr_pick #(.N(NUM_CLIENTS)) u_pick (
    .pend    (pend),
    .rr_ptr  (rr_ptr),
    .win_idx (win_idx),
    .any     (any)
  );

`ifdef I2C_ARB_TIMEOUT_EN
  logic [31:0] to_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op          <= OP_RD;
      rr_ptr      <= '0;
      grant_id    <= '0;
      m_read_req  <= 1'b0;
      m_write_req <= 1'b0;
      m_dev_addr  <= 8'h00;
      m_reg_addr  <= 8'h00;
      m_wdata     <= 8'h00;
      cli_ack     <= '0;
      cli_rdata   <= 8'h00;
      cli_error   <= 1'b0;
      busy        <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      to_cnt      <= 32'd0;
`endif
    end else begin
      cli_ack <= '0;
      case (state)
        S_IDLE: begin
          if (any) begin
            grant_id   <= win_idx;
            m_dev_addr <= cli_dev_addr[8*win_idx +: 8];
            m_reg_addr <= cli_reg_addr[8*win_idx +: 8];
            m_wdata    <= cli_wdata[8*win_idx +: 8];
            // A client raising both requests gets only the write.
            if (cli_wr_req[win_idx]) begin
              op          <= OP_WR;
              m_write_req <= 1'b1;
            end else begin
              op         <= OP_RD;
              m_read_req <= 1'b1;
            end
            busy  <= 1'b1;
            state <= S_ISSUE;
`ifdef I2C_ARB_TIMEOUT_EN
            to_cnt <= 32'd0;
`endif
          end
        end
        S_ISSUE: begin
          if (ack_hit) begin
            if (op == OP_RD) cli_rdata <= m_rdata;
            cli_error         <= m_error;
            m_read_req        <= 1'b0;
            m_write_req       <= 1'b0;
            cli_ack[grant_id] <= 1'b1;
            state             <= S_RESP;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (to_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            cli_rdata         <= 8'h00;
            cli_error         <= 1'b1;
            m_read_req        <= 1'b0;
            m_write_req       <= 1'b0;
            cli_ack[grant_id] <= 1'b1;
            state             <= S_RESP;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
`endif
        end
        S_RESP: begin
          busy   <= 1'b0;
          rr_ptr <= (grant_id == IW'(NUM_CLIENTS - 1)) ? '0 : grant_id + 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
